ic_fill_responder: RTL and testbench

- Memory-side responder for the fetch/icache line-fill request/response interface.
- Accepts line-read requests from the requester, queues them in order, and returns whole lines after a fixed service latency from an internal backing array.
- Sits below the icache in place of a real memory hierarchy; a preload port lets benches and boot code initialise contents.
- A flush input drops all pending work on branch mispredict.

---
 rtl/ic_fill_responder_if.sv | 26 ++
 rtl/ic_fill_responder.sv | 123 ++++++++++++
 tb/tb_ic_fill_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ic_fill_responder_if.sv
// Line-fill request/response bundle between the icache (master) and the fill responder (slave).
interface ic_fill_responder_if #(
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int LINE_BYTES = 64
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [ID_W-1:0]         req_id;
    logic [ADDR_W-1:0]       req_addr;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [ADDR_W-1:0]       rsp_addr;
    logic [8*LINE_BYTES-1:0] rsp_data;

    modport master (
        output req_valid, req_id, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_addr, rsp_data
    );

    modport slave (
        input  req_valid, req_id, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_addr, rsp_data
    );
endinterface

// File: rtl/ic_fill_responder.sv
// Memory-side line-fill responder: in-order request FIFO, fixed service latency,
// preloadable backing array, flush drops all pending work.
module ic_fill_responder #(
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 5,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int LINE_BYTES = 64,
    parameter int MEM_LINES  = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_pl_wren,
    input  logic [$clog2(MEM_LINES)-1:0] i_pl_idx,
    input  logic [8*LINE_BYTES-1:0]      i_pl_data,
    ic_fill_responder_if.slave           bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int TMR_W  = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W:0]     r_wptr, r_rptr;
    logic [ID_W-1:0]    r_q_id   [DEPTH];
    logic [ADDR_W-1:0]  r_q_addr [DEPTH];
    logic [TMR_W-1:0]   r_tmr;
    logic [LINE_W-1:0]  r_mem    [MEM_LINES];
    logic [ID_W-1:0]    r_rsp_id;
    logic [ADDR_W-1:0]  r_rsp_addr;
    logic [LINE_W-1:0]  r_rsp_data;

    logic               w_empty, w_full, w_req_ready, w_push;
    logic               w_pop, w_capture, w_tmr_load;
    logic [PTR_W:0]     w_occ;
    logic [PTR_W-1:0]   w_head;
    logic [IDX_W-1:0]   w_head_idx;

    // Extra wrap bit separates full (MSBs differ) from empty (identical pointers).
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                         (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_occ       = r_wptr - r_rptr;
    assign w_req_ready = !i_flush && !w_full;
    assign w_push      = bus.req_valid && w_req_ready;
    assign w_head      = r_rptr[PTR_W-1:0];
    assign w_head_idx  = r_q_addr[w_head][OFF_W +: IDX_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (!w_empty) w_state_nxt = WAIT;
            WAIT: if (r_tmr == '0) w_state_nxt = RESP;
            RESP: if (bus.rsp_ready)
                      w_state_nxt = (w_occ > (PTR_W+1)'(1) || w_push) ? WAIT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (i_flush) w_state_nxt = IDLE;
    end

    always_comb begin
        w_pop      = (r_state == RESP) && bus.rsp_ready;
        w_capture  = (r_state == WAIT) && (r_tmr == '0);
        w_tmr_load = ((r_state == IDLE) && !w_empty) || w_pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_id[r_wptr[PTR_W-1:0]]   <= bus.req_id;
            r_q_addr[r_wptr[PTR_W-1:0]] <= bus.req_addr & ~ADDR_W'(LINE_BYTES - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         r_tmr <= '0;
        else if (w_tmr_load)               r_tmr <= TMR_W'(LATENCY - 2);
        else if (r_state == WAIT && r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
    end

    // Capture reads the array before a same-edge preload lands, so it sees old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_id   <= '0;
            r_rsp_addr <= '0;
            r_rsp_data <= '0;
        end else if (w_capture) begin
            r_rsp_id   <= r_q_id[w_head];
            r_rsp_addr <= r_q_addr[w_head];
            r_rsp_data <= r_mem[w_head_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (i_pl_wren) r_mem[i_pl_idx] <= i_pl_data;
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_addr  = r_rsp_addr;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_ic_fill_responder.sv
// Scoreboard bench for ic_fill_responder: directed requests push expected lines, a monitor checks responses.
module tb_ic_fill_responder;
    localparam int LW = 512;

    logic          clk = 0, rst = 1, flush = 0, pl_wren = 0;
    logic [9:0]    pl_idx = '0;
    logic [LW-1:0] pl_data = '0;

    ic_fill_responder_if #(.ADDR_W(32), .ID_W(4), .LINE_BYTES(64)) bus ();

    ic_fill_responder #(
        .DEPTH(4), .LATENCY(5), .ADDR_W(32), .ID_W(4), .LINE_BYTES(64), .MEM_LINES(1024)
    ) dut (
        .clk(clk), .reset(rst), .i_flush(flush),
        .i_pl_wren(pl_wren), .i_pl_idx(pl_idx), .i_pl_data(pl_data),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]    id;
        logic [31:0]   addr;
        logic [LW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;

    function automatic logic [LW-1:0] pat(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each new response, checks stability while stalled.
    logic          pend = 0;
    logic [3:0]    s_id;
    logic [31:0]   s_addr;
    logic [LW-1:0] s_data;
    always @(negedge clk) begin
        exp_t e;
        if (rst || !bus.rsp_valid) begin
            pend = 0;
        end else begin
            if (!pend) begin
                pend = 1;
                s_id = bus.rsp_id; s_addr = bus.rsp_addr; s_data = bus.rsp_data;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got id %0d at cycle %0d, expected no response", bus.rsp_id, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_addr", bus.rsp_addr, e.addr);
                    chk("rsp_data", bus.rsp_data, e.data);
                    if (e.cyc >= 0) chk("rsp_cycle", cyc, e.cyc);
                end
            end else begin
                chk("stall_id", bus.rsp_id, s_id);
                chk("stall_addr", bus.rsp_addr, s_addr);
                chk("stall_data", bus.rsp_data, s_data);
            end
            if (bus.rsp_ready) pend = 0;
        end
    end

    // All tasks start and end one time unit after a rising edge.
    task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [LW-1:0] data,
                        input int lat, output int t, output int waits);
        exp_t e;
        bus.req_valid = 1; bus.req_id = id; bus.req_addr = addr;
        waits = 0; t = -1;
        @(negedge clk);
        while (!bus.req_ready && waits < 50) begin
            @(posedge clk); #1; waits++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: id %0d not accepted, expected acceptance", id);
        end
        @(posedge clk); #1;
        if (waits < 50) begin
            t = cyc;
            e.id = id; e.addr = addr & 32'hFFFF_FFC0; e.data = data;
            e.cyc = (lat < 0) ? -1 : t + lat;
            sb.push_back(e);
        end
        bus.req_valid = 0;
    endtask

    task automatic preload(input int idx, input logic [LW-1:0] d);
        pl_wren = 1; pl_idx = idx[9:0]; pl_data = d;
        @(posedge clk); #1;
        pl_wren = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.rsp_valid) && n < 100) begin
            @(negedge clk); n++;
        end
        chk(name, (sb.size() != 0 || bus.rsp_valid), 0);
        @(posedge clk); #1;
    endtask

    initial begin : main
        int t, w, t4, t5, w5, n;
        bus.req_valid = 0; bus.req_id = '0; bus.req_addr = '0; bus.rsp_ready = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_id", bus.rsp_id, 0);
        chk("reset_rsp_addr", bus.rsp_addr, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        @(posedge clk); #1;

        preload(3, pat(8'hA5));
        for (int i = 0; i < 4; i++) preload(64 + i, pat(8'(8'h10 + i)));

        // Single request, idle responder: LATENCY cycles, one-cycle valid
        bus.rsp_ready = 1;
        send(4'd2, 32'h0000_00C4, pat(8'hA5), 5, t, w);
        drain("drain_single");

        // Back-to-back: responses every LATENCY cycles once running
        for (int i = 0; i < 4; i++) begin
            send(4'(i), 32'h1000 + 32'(64 * i), pat(8'(8'h10 + i)), 5 + 4 * i, t, w);
            chk("b2b_req_ready_wait", w, 0);
        end
        drain("drain_b2b");

        // Backpressure: fill the queue, fifth waits for the first pop
        bus.rsp_ready = 0;
        for (int i = 0; i < 4; i++) begin
            send(4'(4 + i), 32'h1000 + 32'(64 * i), pat(8'(8'h10 + i)), -1, t, w);
            chk("fill_req_ready_wait", w, 0);
        end
        t4 = t;
        @(negedge clk);
        chk("full_req_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        fork
            send(4'd8, 32'h0000_00C4, pat(8'hA5), -1, t5, w5);
            begin
                repeat (10) @(posedge clk);
                #1 bus.rsp_ready = 1;
            end
        join
        chk("fifth_accept_cycle", t5, t4 + 13);
        drain("drain_full");

        // Flush while a response is pending
        bus.rsp_ready = 0;
        send(4'd9,  32'h1000, pat(8'h10), -1, t, w);
        send(4'd10, 32'h1040, pat(8'h11), -1, t, w);
        send(4'd11, 32'h1080, pat(8'h12), -1, t, w);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 30) begin @(negedge clk); n++; end
        chk("flush_rsp_seen", bus.rsp_valid, 1);
        @(posedge clk); #1 flush = 1;
        @(negedge clk);
        chk("flush_cycle_req_ready", bus.req_ready, 0);
        @(posedge clk); #1 flush = 0;
        sb.delete();
        bus.rsp_ready = 1;
        @(negedge clk);
        chk("post_flush_rsp_valid", bus.rsp_valid, 0);
        chk("post_flush_req_ready", bus.req_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        send(4'd12, 32'h1040, pat(8'h11), 5, t, w);
        drain("drain_after_flush");

        // Preload colliding with the capture edge returns the old line
        preload(7, pat(8'h3C));
        send(4'd13, 32'h0000_01C0, pat(8'h3C), 5, t, w);
        repeat (4) @(posedge clk);
        #1 pl_wren = 1; pl_idx = 10'd7; pl_data = pat(8'hC3);
        @(posedge clk);
        #1 pl_wren = 0;
        drain("drain_collide");
        send(4'd14, 32'h0000_01C0, pat(8'hC3), 5, t, w);
        drain("drain_new_data");

        // Asynchronous reset mid-WAIT
        send(4'd15, 32'h0000_00C4, pat(8'hA5), 5, t, w);
        repeat (2) @(posedge clk);
        #3 rst = 1;
        sb.delete();
        #1;
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_req_ready", bus.req_ready, 1);
        chk("async_rst_rsp_id", bus.rsp_id, 0);
        @(posedge clk); #1 rst = 0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("post_reset_idle", bus.rsp_valid, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: still running at cycle %0d, expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
